// File: rtl/mfc_pkg.sv
// mfc_pkg: shared definitions for the match filter sequencer.
//   - state_e   : sequencer states, encoding visible on state_dbg
//   - CSTATE_W  : width of the filter config address (cstate)
//   - *_DEF     : default sizing for match_filter_ctrl
//   - CFG_*     : bit fields inside a 32-bit config word
package mfc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_WARMUP = 3'd3,
    ST_RUN    = 3'd4
  } state_e;

  localparam int CSTATE_W           = 3;
  localparam int NUM_WORDS_DEF      = 8;
  localparam int DRAIN_CYC_DEF      = 24;
  localparam int WARMUP_SAMPLES_DEF = 128;
  localparam int CNT_W_DEF          = 16;

  // Upper half: threshold / real coefficient; lower half: imaginary
  // coefficient / offset.
  localparam int CFG_HI_MSB = 31;
  localparam int CFG_HI_LSB = 16;
  localparam int CFG_LO_MSB = 15;
  localparam int CFG_LO_LSB = 0;

endpackage

// File: rtl/mfc_sat_counter.sv
// mfc_sat_counter: statistics counter that sticks at all-ones.
// Ports:
//   clk_i   - system clock
//   clr_i   - synchronous clear (wins over inc_i)
//   inc_i   - add one this cycle unless already saturated
//   count_o - current count
module mfc_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // Count up on each increment request but never wrap, so a long
  // unattended run still shows "at least this many" rather than garbage.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/match_filter_ctrl.sv
// match_filter_ctrl: sequencer in front of the correlating match filter.
// Owns the filter config write port and its sample strobe so coefficient
// loads never overlap a computation window, masks stale matches while the
// filter refills after a load, and turns valid/match into an acknowledged,
// held-off event with saturating statistics.
//
// Optional build macro: MATCH_FILTER_CTRL_TIMESTAMP_EN adds a 32-bit
// forwarded-strobe counter captured into event_ts; without it event_ts is 0.
//
// Ports:
//   clk, reset (sync, active-low)
//   load_start                      - request a config reload
//   cfg_valid/cfg_ready/cfg_data    - config word handshake (LOAD only)
//   rxstrobe_in -> filt_rxstrobe    - gated sample strobe
//   filt_cwrite/cstate/cdata        - filter config write port
//   filt_valid, filt_match          - filter result
//   holdoff_len                     - cycles of match blanking after an event
//   event_valid/event_ack/event_ts  - match event to the consumer
//   match_cnt/drop_cnt/ovf_cnt      - saturating statistics
//   state_dbg                       - current state encoding
module match_filter_ctrl
  import mfc_pkg::*;
#(
  parameter int NUM_WORDS      = NUM_WORDS_DEF,
  parameter int DRAIN_CYC      = DRAIN_CYC_DEF,
  parameter int WARMUP_SAMPLES = WARMUP_SAMPLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [31:0]         cfg_data,
  input  logic                rxstrobe_in,
  output logic                filt_rxstrobe,
  output logic                filt_cwrite,
  output logic [CSTATE_W-1:0] filt_cstate,
  output logic [31:0]         filt_cdata,
  input  logic                filt_valid,
  input  logic                filt_match,
  input  logic [15:0]         holdoff_len,
  output logic                event_valid,
  input  logic                event_ack,
  output logic [31:0]         event_ts,
  output logic [CNT_W-1:0]    match_cnt,
  output logic [CNT_W-1:0]    drop_cnt,
  output logic [CNT_W-1:0]    ovf_cnt,
  output logic [2:0]          state_dbg
);

  localparam int WCNT_W = $clog2(NUM_WORDS + 1);
  localparam int BUSY_W = $clog2(DRAIN_CYC + 1);
  localparam int WARM_W = $clog2(WARMUP_SAMPLES + 1);

  state_e                state_q, state_d;
  logic [BUSY_W-1:0]     busy_q, busy_d;
  logic [WCNT_W-1:0]     word_cnt_q, word_cnt_d;
  logic [WARM_W-1:0]     warm_cnt_q, warm_cnt_d;
  logic [15:0]           holdoff_q, holdoff_d;
  logic                  event_q, event_d;
  logic                  cwrite_q, cwrite_d;
  logic [CSTATE_W-1:0]   cstate_q, cstate_d;
  logic [31:0]           cdata_q, cdata_d;

  logic fwd_en, strobe_fwd, strobe_drop;
  logic cfg_ready_c, cfg_accept;
  logic match_hit, event_accept, event_ovf;

  // Strobes reach the filter only when no config write can be in flight.
  // cfg_ready drops once the last word is taken so the final cwrite cycle
  // still happens while LOAD is blocking the strobe.
  always_comb begin
    fwd_en       = (state_q == ST_IDLE) || (state_q == ST_WARMUP) || (state_q == ST_RUN);
    strobe_fwd   = rxstrobe_in && fwd_en;
    strobe_drop  = rxstrobe_in && !fwd_en;
    cfg_ready_c  = (state_q == ST_LOAD) && (word_cnt_q != WCNT_W'(NUM_WORDS));
    cfg_accept   = cfg_valid && cfg_ready_c;
    match_hit    = (state_q == ST_RUN) && filt_valid && filt_match && (holdoff_q == '0);
    event_accept = match_hit && (!event_q || event_ack);
    event_ovf    = match_hit && event_q && !event_ack;
  end

  // Sequencer next state. The word index restarts on every DRAIN entry and
  // the warm-up count restarts on every WARMUP entry; a reload request
  // takes priority over finishing the warm-up.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    warm_cnt_d = warm_cnt_q;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (load_start) begin
          state_d    = ST_DRAIN;
          word_cnt_d = '0;
        end
      end
      ST_WARMUP: begin
        if (load_start) begin
          state_d    = ST_DRAIN;
          word_cnt_d = '0;
        end else if (strobe_fwd) begin
          if (warm_cnt_q == WARM_W'(WARMUP_SAMPLES - 1)) begin
            state_d = ST_RUN;
          end
          warm_cnt_d = warm_cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (busy_q == '0) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (cfg_accept) begin
          word_cnt_d = word_cnt_q + 1'b1;
        end
        if (word_cnt_q == WCNT_W'(NUM_WORDS)) begin
          state_d    = ST_WARMUP;
          warm_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: busy window refreshed by each forwarded strobe,
  // config write registered one cycle after acceptance, holdoff reloaded
  // by every qualifying match (accepted or overflowed), and a new event
  // beating a same-cycle acknowledge.
  always_comb begin
    busy_d    = busy_q;
    holdoff_d = holdoff_q;
    event_d   = event_q;
    cwrite_d  = cfg_accept;
    cstate_d  = cstate_q;
    cdata_d   = cdata_q;
    if (strobe_fwd) begin
      busy_d = BUSY_W'(DRAIN_CYC);
    end else if (busy_q != '0) begin
      busy_d = busy_q - 1'b1;
    end
    if (cfg_accept) begin
      cstate_d = CSTATE_W'(word_cnt_q);
      cdata_d  = {cfg_data[CFG_HI_MSB:CFG_HI_LSB], cfg_data[CFG_LO_MSB:CFG_LO_LSB]};
    end
    if (match_hit) begin
      holdoff_d = holdoff_len;
    end else if (holdoff_q != '0) begin
      holdoff_d = holdoff_q - 16'd1;
    end
    if (event_accept) begin
      event_d = 1'b1;
    end else if (event_ack) begin
      event_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= '0;
      word_cnt_q <= '0;
      warm_cnt_q <= '0;
      holdoff_q  <= '0;
      event_q    <= 1'b0;
      cwrite_q   <= 1'b0;
      cstate_q   <= '0;
      cdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      word_cnt_q <= word_cnt_d;
      warm_cnt_q <= warm_cnt_d;
      holdoff_q  <= holdoff_d;
      event_q    <= event_d;
      cwrite_q   <= cwrite_d;
      cstate_q   <= cstate_d;
      cdata_q    <= cdata_d;
    end
  end

`ifdef MATCH_FILTER_CTRL_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] event_ts_q;

  // Free-running count of forwarded strobes, snapshotted when an event is
  // raised and held until the next one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ts_q       <= '0;
      event_ts_q <= '0;
    end else begin
      if (strobe_fwd) begin
        ts_q <= ts_q + 32'd1;
      end
      if (event_accept) begin
        event_ts_q <= ts_q;
      end
    end
  end

  assign event_ts = event_ts_q;
`else
  assign event_ts = '0;
`endif

  // Statistics survive reloads; only reset clears them.
  mfc_sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk_i(clk), .clr_i(!reset), .inc_i(event_accept), .count_o(match_cnt)
  );
  mfc_sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk_i(clk), .clr_i(!reset), .inc_i(strobe_drop), .count_o(drop_cnt)
  );
  mfc_sat_counter #(.W(CNT_W)) u_ovf_cnt (
    .clk_i(clk), .clr_i(!reset), .inc_i(event_ovf), .count_o(ovf_cnt)
  );

  assign cfg_ready     = cfg_ready_c;
  assign filt_rxstrobe = strobe_fwd;
  assign filt_cwrite   = cwrite_q;
  assign filt_cstate   = cstate_q;
  assign filt_cdata    = cdata_q;
  assign event_valid   = event_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_match_filter_ctrl.sv
// tb_match_filter_ctrl: directed, self-checking bench for match_filter_ctrl.
// Inputs change 1 time unit after a rising edge; registered outputs are
// examined 1 unit after the edge, combinational ones after a further unit.
module tb_match_filter_ctrl;

  logic        clk;
  logic        reset;
  logic        load_start;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_data;
  logic        rxstrobe_in;
  logic        filt_rxstrobe;
  logic        filt_cwrite;
  logic [2:0]  filt_cstate;
  logic [31:0] filt_cdata;
  logic        filt_valid;
  logic        filt_match;
  logic [15:0] holdoff_len;
  logic        event_valid;
  logic        event_ack;
  logic [31:0] event_ts;
  logic [15:0] match_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] ovf_cnt;
  logic [2:0]  state_dbg;

  int total;
  int bad;
  int cyc;
  int collide;
  int cwCyc[$];

  match_filter_ctrl dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .rxstrobe_in(rxstrobe_in), .filt_rxstrobe(filt_rxstrobe),
    .filt_cwrite(filt_cwrite), .filt_cstate(filt_cstate), .filt_cdata(filt_cdata),
    .filt_valid(filt_valid), .filt_match(filt_match), .holdoff_len(holdoff_len),
    .event_valid(event_valid), .event_ack(event_ack), .event_ts(event_ts),
    .match_cnt(match_cnt), .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index used to time-stamp observed config writes.
  always @(posedge clk) cyc <= cyc + 1;

  // Log every cycle with a config write and flag any overlap with a strobe.
  always @(negedge clk) begin
    if (filt_cwrite) cwCyc.push_back(cyc);
    if (filt_cwrite && filt_rxstrobe) collide++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive all stimulus inputs for the coming cycle and let them settle.
  task automatic applyStimulus(input logic ls, input logic cv, input logic [31:0] cd,
                               input logic rx, input logic vm, input logic ack);
    load_start  = ls;
    cfg_valid   = cv;
    cfg_data    = cd;
    rxstrobe_in = rx;
    filt_valid  = vm;
    filt_match  = vm;
    event_ack   = ack;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer eight consecutive words; each must appear on the write port one
  // cycle after its acceptance edge with the matching index.
  task automatic loadWords(input logic [31:0] base);
    int guard;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b1, base + 32'(k), 1'b0, 1'b0, 1'b0);
      guard = 0;
      while (!cfg_ready && guard < 64) begin
        tick();
        guard++;
      end
      checkOutput("cfgReadyWait", {31'd0, cfg_ready}, 32'd1);
      tick();
      checkOutput("cwrite", {31'd0, filt_cwrite}, 32'd1);
      checkOutput("cstate", {29'd0, filt_cstate}, 32'(k));
      checkOutput("cdata", filt_cdata, base + 32'(k));
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Forward n single-cycle strobes separated by one idle cycle.
  task automatic strobes(input int n, input logic vm);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, vm, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, vm, 1'b0);
      tick();
    end
  endtask

  initial begin
    int sCyc;
    int sent;
    int firstCw;
    logic [31:0] expTs;
    total = 0; bad = 0; cyc = 0; collide = 0;
    reset = 1'b0;
    holdoff_len = 16'd0;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick();

    // Reset state
    checkOutput("rstState", {29'd0, state_dbg}, 32'd0);
    checkOutput("rstCfgReady", {31'd0, cfg_ready}, 32'd0);
    checkOutput("rstCwrite", {31'd0, filt_cwrite}, 32'd0);
    checkOutput("rstEvent", {31'd0, event_valid}, 32'd0);
    checkOutput("rstMatchCnt", {16'd0, match_cnt}, 32'd0);
    checkOutput("rstEventTs", event_ts, 32'd0);
    reset = 1'b1;
    tick();

    // Back-to-back load of 0xA0000000..0xA0000007
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    loadWords(32'hA000_0000);
    tick();
    checkOutput("loadEndCwrite", {31'd0, filt_cwrite}, 32'd0);
    checkOutput("loadEndState", {29'd0, state_dbg}, 32'd3);
    checkOutput("loadEndReady", {31'd0, cfg_ready}, 32'd0);
    checkOutput("cwriteCount1", 32'(cwCyc.size()), 32'd8);

    // Reload right after a forwarded strobe, strobes every 4 cycles.
    // Strobe at off 0 -> busy 24 at off 1 ... 0 at off 25, LOAD at off 26,
    // first word accepted that cycle, first cwrite at off 27. DRAIN/LOAD
    // cover off 2..34, so strobes at off 4..32 (8 of them) are dropped.
    sCyc = cyc;
    sent = 0;
    for (int off = 0; off < 40; off++) begin
      applyStimulus(off == 1, sent < 8, 32'hB000_0000 + 32'(sent), (off % 4) == 0, 1'b0, 1'b0);
      if (off == 0) checkOutput("strobeFwdWarmup", {31'd0, filt_rxstrobe}, 32'd1);
      if (off == 4) checkOutput("strobeBlockDrain", {31'd0, filt_rxstrobe}, 32'd0);
      if (cfg_ready && cfg_valid) sent++;
      tick();
    end
    firstCw = (cwCyc.size() > 8) ? cwCyc[8] : -1;
    checkOutput("drainFirstCwrite", 32'(firstCw), 32'(sCyc + 27));
    checkOutput("drainDropCnt", {16'd0, drop_cnt}, 32'd8);
    checkOutput("drainState", {29'd0, state_dbg}, 32'd3);
    checkOutput("cwriteCount2", 32'(cwCyc.size()), 32'd16);

    // Warm-up: 1 strobe already forwarded at off 36; 126 more make 127,
    // all with valid&match held high -> nothing honoured.
    strobes(126, 1'b1);
    checkOutput("warm127State", {29'd0, state_dbg}, 32'd3);
    checkOutput("warm127Event", {31'd0, event_valid}, 32'd0);
    checkOutput("warm127MatchCnt", {16'd0, match_cnt}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("warm128State", {29'd0, state_dbg}, 32'd4);
    checkOutput("warm128Event", {31'd0, event_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("runFirstEvent", {31'd0, event_valid}, 32'd1);
    checkOutput("runFirstMatchCnt", {16'd0, match_cnt}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("ackClears", {31'd0, event_valid}, 32'd0);

    // Holdoff 10: matches at 0, 5, 11, ack at 1 -> events at 0 and 11.
    holdoff_len = 16'd10;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, (c == 0) || (c == 5) || (c == 11), c == 1);
      tick();
      if (c == 0) checkOutput("hold0Event", {31'd0, event_valid}, 32'd1);
      if (c == 5) checkOutput("hold5Event", {31'd0, event_valid}, 32'd0);
      if (c == 11) checkOutput("hold11Event", {31'd0, event_valid}, 32'd1);
    end
    checkOutput("holdMatchCnt", {16'd0, match_cnt}, 32'd3);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("ackIdleEvent", {31'd0, event_valid}, 32'd0);
    checkOutput("ackIdleMatchCnt", {16'd0, match_cnt}, 32'd3);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (12) tick();

    // No ack, holdoff 0: matches at 0, 20, 40 -> one event, two overflows.
    holdoff_len = 16'd0;
    for (int c = 0; c <= 40; c++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, (c % 20) == 0, 1'b0);
      tick();
    end
    checkOutput("ovfEvent", {31'd0, event_valid}, 32'd1);
    checkOutput("ovfMatchCnt", {16'd0, match_cnt}, 32'd4);
    checkOutput("ovfOvfCnt", {16'd0, ovf_cnt}, 32'd2);

    // Reload does not clear statistics.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("reloadState", {29'd0, state_dbg}, 32'd1);
    checkOutput("reloadKeepsCnt", {16'd0, match_cnt}, 32'd4);
    checkOutput("reloadKeepsDrop", {16'd0, drop_cnt}, 32'd8);

    // Reset mid-drain, then timestamp after 128 + 172 = 300 forwarded strobes.
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    checkOutput("rst2State", {29'd0, state_dbg}, 32'd0);
    checkOutput("rst2MatchCnt", {16'd0, match_cnt}, 32'd0);
    checkOutput("rst2OvfCnt", {16'd0, ovf_cnt}, 32'd0);
    checkOutput("rst2Event", {31'd0, event_valid}, 32'd0);
    reset = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    loadWords(32'hC000_0000);
    tick();
    strobes(128, 1'b0);
    checkOutput("tsRunState", {29'd0, state_dbg}, 32'd4);
    strobes(172, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
`ifdef MATCH_FILTER_CTRL_TIMESTAMP_EN
    expTs = 32'd300;
`else
    expTs = 32'd0;
`endif
    checkOutput("tsEvent", {31'd0, event_valid}, 32'd1);
    checkOutput("tsValue", event_ts, expTs);
    checkOutput("tsMatchCnt", {16'd0, match_cnt}, 32'd1);
    checkOutput("noCwriteStrobeOverlap", 32'(collide), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
